// File: rtl/mem_access_unit.sv
// Load/store front-end to a word-organised SRAM with sub-word read-modify-write.
// Define MEM_ACCESS_STATS_EN to build the saturating load/store/error counters.
module mem_access_unit #(
    parameter int addr_width = 16,
    parameter int data_width = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [addr_width+1:0] req_addr,
    input  logic [data_width-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [data_width-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [addr_width-1:0] mem_addr,
    output logic [data_width-1:0] mem_wr_data,
    input  logic [data_width-1:0] mem_data,
    output logic [15:0]           stat_loads,
    output logic [15:0]           stat_stores,
    output logic [15:0]           stat_errs
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_MERGE = 3'd2;
    localparam logic [2:0] S_STORE = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;

    logic [2:0]            state;
    logic [1:0]            size_q;
    logic                  signed_q;
    logic [addr_width+1:0] addr_q;
    logic [15:0]           wdata_q;
    logic [data_width-1:0] wr_word;

    logic                  req_illegal;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [data_width-1:0] ld_ext;
    logic [data_width-1:0] merged;

    always_comb begin
        req_illegal = (req_size == 2'b11) ||
                      (req_size == 2'b01 && req_addr[0]) ||
                      (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    end

    always_comb begin
        case (addr_q[1:0])
            2'd0:    ld_byte = mem_data[7:0];
            2'd1:    ld_byte = mem_data[15:8];
            2'd2:    ld_byte = mem_data[23:16];
            default: ld_byte = mem_data[31:24];
        endcase
        ld_half = addr_q[1] ? mem_data[31:16] : mem_data[15:0];
        case (size_q)
            2'b00:   ld_ext = {{24{signed_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = {{16{signed_q & ld_half[15]}}, ld_half};
            default: ld_ext = mem_data;
        endcase
    end

    // Sub-word store: replace only the addressed lane(s) of the current word.
    always_comb begin
        merged = mem_data;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q;
        end else begin
            merged[15:0] = wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            size_q     <= 2'b00;
            signed_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_word    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata[15:0];
                        if (req_illegal) begin
                            state <= S_ERR;
                        end else if (!req_we) begin
                            state <= S_LOAD;
                        end else if (req_size == 2'b10) begin
                            wr_word <= req_wdata;
                            state   <= S_STORE;
                        end else begin
                            state <= S_MERGE;
                        end
                    end
                end
                S_LOAD: begin
                    resp_rdata <= ld_ext;
                    resp_err   <= 1'b0;
                    state      <= S_RESP;
                end
                S_MERGE: begin
                    wr_word <= merged;
                    state   <= S_STORE;
                end
                S_STORE: begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                    state      <= S_RESP;
                end
                S_ERR: begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b1;
                    state      <= S_RESP;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);

    // Write is gated by rst so an in-flight store cannot land during reset.
    assign mem_en      = (state == S_LOAD) || (state == S_MERGE) || (state == S_STORE);
    assign mem_we      = (state == S_STORE) && !rst;
    assign mem_addr    = mem_en ? addr_q[addr_width+1:2] : '0;
    assign mem_wr_data = (state == S_STORE) ? wr_word : '0;

`ifdef MEM_ACCESS_STATS_EN
    logic        we_q;
    logic [15:0] loads_q;
    logic [15:0] stores_q;
    logic [15:0] errs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q     <= 1'b0;
            loads_q  <= '0;
            stores_q <= '0;
            errs_q   <= '0;
        end else begin
            if (state == S_IDLE && req_valid) begin
                we_q <= req_we;
            end
            if (state == S_RESP) begin
                if (resp_err) begin
                    if (errs_q != 16'hFFFF) errs_q <= errs_q + 16'd1;
                end else if (we_q) begin
                    if (stores_q != 16'hFFFF) stores_q <= stores_q + 16'd1;
                end else begin
                    if (loads_q != 16'hFFFF) loads_q <= loads_q + 16'd1;
                end
            end
        end
    end

    assign stat_loads  = loads_q;
    assign stat_stores = stores_q;
    assign stat_errs   = errs_q;
`else
    assign stat_loads  = '0;
    assign stat_stores = '0;
    assign stat_errs   = '0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed test-plan sequences plus a vector table.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [17:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_data;
    logic [15:0] stat_loads;
    logic [15:0] stat_stores;
    logic [15:0] stat_errs;

    mem_access_unit #(.addr_width(16), .data_width(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_data    (mem_data),
        .stat_loads  (stat_loads),
        .stat_stores (stat_stores),
        .stat_errs   (stat_errs)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM model: combinational read, negedge write; preload port shares the write process.
    logic [31:0] sram [0:65535];
    logic        pre_we;
    logic [15:0] pre_addr;
    logic [31:0] pre_data;
    int          en_cnt;
    int          we_cnt;

    assign mem_data = sram[mem_addr];

    initial begin
        en_cnt = 0;
        we_cnt = 0;
    end

    always @(negedge clk) begin
        if (mem_en) en_cnt = en_cnt + 1;
        if (mem_en && mem_we) begin
            we_cnt = we_cnt + 1;
            sram[mem_addr] <= mem_wr_data;
        end else if (pre_we) begin
            sram[pre_addr] <= pre_data;
        end
    end

    int n_checks;
    int n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [15:0] widx, input logic [31:0] val);
        @(negedge clk);
        pre_addr = widx;
        pre_data = val;
        pre_we   = 1'b1;
        @(negedge clk);
        #1 pre_we = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [17:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output logic seen,
                          output int lat, output int en_d, output int we_d);
        int en0;
        int we0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        en0 = en_cnt;
        we0 = we_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_wdata = 32'h0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk);
            #1 lat++;
        end
        seen  = resp_valid;
        rdata = resp_rdata;
        err   = resp_err;
        en_d  = en_cnt - en0;
        we_d  = we_cnt - we0;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [17:0] addr;
        logic [31:0] wdata;
        logic [31:0] init;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [31:0] exp_word;
        int          exp_lat;
    } vec_t;

    vec_t vecs [14];

    initial begin
        logic [31:0] rd;
        logic        er;
        logic        sv;
        int          lat;
        int          en_d;
        int          we_d;
        int          nrv;
        int          t_loads;
        int          t_stores;
        int          t_errs;
        logic [15:0] widx;

        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        pre_we     = 1'b0;
        pre_addr   = '0;
        pre_data   = '0;

        vecs[0]  = '{1'b0, 2'b00, 1'b0, 18'h40, 32'h0,        32'h8899AABB, 32'h000000BB, 1'b0, 32'h8899AABB, 2};
        vecs[1]  = '{1'b0, 2'b00, 1'b1, 18'h43, 32'h0,        32'h8899AABB, 32'hFFFFFF88, 1'b0, 32'h8899AABB, 2};
        vecs[2]  = '{1'b0, 2'b00, 1'b1, 18'h41, 32'h0,        32'h11223344, 32'h00000033, 1'b0, 32'h11223344, 2};
        vecs[3]  = '{1'b0, 2'b01, 1'b1, 18'h40, 32'h0,        32'h8899AABB, 32'hFFFFAABB, 1'b0, 32'h8899AABB, 2};
        vecs[4]  = '{1'b0, 2'b01, 1'b1, 18'h42, 32'h0,        32'h12347FFF, 32'h00001234, 1'b0, 32'h12347FFF, 2};
        vecs[5]  = '{1'b0, 2'b10, 1'b1, 18'h44, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 2};
        vecs[6]  = '{1'b1, 2'b01, 1'b0, 18'h46, 32'h1234BEEF, 32'hCAFEF00D, 32'h00000000, 1'b0, 32'hBEEFF00D, 3};
        vecs[7]  = '{1'b1, 2'b00, 1'b0, 18'h4B, 32'hFFFFFF77, 32'h8899AABB, 32'h00000000, 1'b0, 32'h7799AABB, 3};
        vecs[8]  = '{1'b1, 2'b00, 1'b0, 18'h42, 32'h000000A5, 32'h8899AABB, 32'h00000000, 1'b0, 32'h88A5AABB, 3};
        vecs[9]  = '{1'b1, 2'b10, 1'b0, 18'h48, 32'h01020304, 32'h8899AABB, 32'h00000000, 1'b0, 32'h01020304, 2};
        vecs[10] = '{1'b1, 2'b01, 1'b0, 18'h45, 32'h00001111, 32'h8899AABB, 32'h00000000, 1'b1, 32'h8899AABB, 2};
        vecs[11] = '{1'b0, 2'b10, 1'b0, 18'h42, 32'h0,        32'h8899AABB, 32'h00000000, 1'b1, 32'h8899AABB, 2};
        vecs[12] = '{1'b0, 2'b11, 1'b0, 18'h40, 32'h0,        32'h8899AABB, 32'h00000000, 1'b1, 32'h8899AABB, 2};
        vecs[13] = '{1'b1, 2'b01, 1'b0, 18'h44, 32'h0000C3C3, 32'h8899AABB, 32'h00000000, 1'b0, 32'h8899C3C3, 3};

        repeat (3) @(posedge clk);
        #1;
        check("reset req_ready", {31'b0, req_ready}, 32'd1);
        check("reset resp_valid", {31'b0, resp_valid}, 32'd0);
        check("reset mem_we", {31'b0, mem_we}, 32'd0);
        check("reset mem_en", {31'b0, mem_en}, 32'd0);
        check("reset resp_rdata", resp_rdata, 32'd0);
        check("reset resp_err", {31'b0, resp_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        preload(16'h10, 32'h8899AABB);

        do_req(1'b0, 2'b00, 1'b1, 18'h42, 32'h0, rd, er, sv, lat, en_d, we_d);
        check("plan lb signed seen", {31'b0, sv}, 32'd1);
        check("plan lb signed rdata", rd, 32'hFFFFFF99);
        check("plan lb signed latency", lat, 2);

        do_req(1'b0, 2'b01, 1'b0, 18'h42, 32'h0, rd, er, sv, lat, en_d, we_d);
        check("plan lh unsigned rdata", rd, 32'h00008899);
        check("plan lh unsigned err", {31'b0, er}, 32'd0);

        do_req(1'b0, 2'b10, 1'b0, 18'h40, 32'h0, rd, er, sv, lat, en_d, we_d);
        check("plan lw rdata", rd, 32'h8899AABB);

        do_req(1'b1, 2'b00, 1'b0, 18'h41, 32'h0000005A, rd, er, sv, lat, en_d, we_d);
        check("plan sb latency", lat, 3);
        check("plan sb we cycles", we_d, 1);
        check("plan sb sram word", sram[16'h10], 32'h88995ABB);

        do_req(1'b0, 2'b01, 1'b0, 18'h43, 32'h0, rd, er, sv, lat, en_d, we_d);
        check("plan misaligned lh err", {31'b0, er}, 32'd1);
        check("plan misaligned lh rdata", rd, 32'd0);
        check("plan misaligned lh mem_en cycles", en_d, 0);
        check("plan misaligned lh latency", lat, 2);

        do_req(1'b1, 2'b11, 1'b0, 18'h40, 32'hFFFFFFFF, rd, er, sv, lat, en_d, we_d);
        check("plan size11 store err", {31'b0, er}, 32'd1);
        check("plan size11 store mem_en cycles", en_d, 0);
        check("plan size11 sram word", sram[16'h10], 32'h88995ABB);

`ifdef MEM_ACCESS_STATS_EN
        check("plan stat_loads", {16'b0, stat_loads}, 32'd3);
        check("plan stat_stores", {16'b0, stat_stores}, 32'd1);
        check("plan stat_errs", {16'b0, stat_errs}, 32'd2);
`else
        check("plan stat_loads off", {16'b0, stat_loads}, 32'd0);
        check("plan stat_stores off", {16'b0, stat_stores}, 32'd0);
        check("plan stat_errs off", {16'b0, stat_errs}, 32'd0);
`endif

        // Reset asserted while the word store sits in its write cycle.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 18'h40;
        req_wdata = 32'hDEADBEEF;
        we_d      = we_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("abort mem_we before rst", {31'b0, mem_we}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort mem_we during rst", {31'b0, mem_we}, 32'd0);
        @(posedge clk);
        #1;
        check("abort resp_valid", {31'b0, resp_valid}, 32'd0);
        check("abort req_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        nrv = 0;
        repeat (4) begin
            @(posedge clk);
            #1 if (resp_valid) nrv++;
        end
        check("abort no late resp", nrv, 0);
        check("abort no write", we_cnt - we_d, 0);
        check("abort sram word", sram[16'h10], 32'h88995ABB);
        check("abort stat_loads", {16'b0, stat_loads}, 32'd0);
        check("abort stat_errs", {16'b0, stat_errs}, 32'd0);

        t_loads  = 0;
        t_stores = 0;
        t_errs   = 0;
        for (int i = 0; i < 14; i++) begin
            widx = vecs[i].addr[17:2];
            preload(widx, vecs[i].init);
            do_req(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                   rd, er, sv, lat, en_d, we_d);
            check($sformatf("vec%0d resp_valid", i), {31'b0, sv}, 32'd1);
            check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
            check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d sram word", i), sram[widx], vecs[i].exp_word);
            if (vecs[i].exp_err) begin
                t_errs++;
                check($sformatf("vec%0d mem_en cycles", i), en_d, 0);
                check($sformatf("vec%0d we cycles", i), we_d, 0);
            end else if (vecs[i].we) begin
                t_stores++;
                check($sformatf("vec%0d mem_en cycles", i), en_d, (vecs[i].size == 2'b10) ? 1 : 2);
                check($sformatf("vec%0d we cycles", i), we_d, 1);
            end else begin
                t_loads++;
                check($sformatf("vec%0d mem_en cycles", i), en_d, 1);
                check($sformatf("vec%0d we cycles", i), we_d, 0);
            end
        end

`ifdef MEM_ACCESS_STATS_EN
        check("table stat_loads", {16'b0, stat_loads}, t_loads);
        check("table stat_stores", {16'b0, stat_stores}, t_stores);
        check("table stat_errs", {16'b0, stat_errs}, t_errs);
`else
        check("table stat_loads off", {16'b0, stat_loads}, 32'd0);
        check("table stat_stores off", {16'b0, stat_stores}, 32'd0);
        check("table stat_errs off", {16'b0, stat_errs}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front-end between the core's execute/memory stage and the word-organised `sram` data memory.
- Accepts byte-addressed byte, halfword and word loads/stores from the core.
- Performs alignment checks, lane extraction and sign/zero extension.
- Performs read-modify-write for sub-word stores, because `sram` has no byte enables.
- Drives the `sram` port: combinational read, negedge write.

Parameters:
- addr_width, 16: word-address width driven to `sram`; byte address is addr_width+2 bits.
- data_width, 32: `sram` word width; only 32 is supported.

Ports:
- clk, input, 1: clock; all state updates on posedge.
- rst, input, 1: synchronous, active-high reset.
- req_valid, input, 1: request present.
- req_ready, output, 1: unit can accept; high only in IDLE.
- req_we, input, 1: 1 = store, 0 = load.
- req_size, input, 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- req_signed, input, 1: loads only; sign-extend when 1, zero-extend when 0.
- req_addr, input, addr_width+2: byte address.
- req_wdata, input, 32: store data, right-aligned (byte in [7:0], halfword in [15:0]).
- resp_valid, output, 1: one-cycle completion pulse; no backpressure.
- resp_rdata, output, 32: extended load data; 0 for stores and errors.
- resp_err, output, 1: misaligned or illegal request; valid with resp_valid.
- mem_en, output, 1: `sram` enable.
- mem_we, output, 1: `sram` write enable; `sram` writes at negedge.
- mem_addr, output, addr_width: word address = req_addr[addr_width+1:2].
- mem_wr_data, output, 32: write word.
- mem_data, input, 32: `sram` combinational read data.
- stat_loads, output, 16: see Optional Feature.
- stat_stores, output, 16: see Optional Feature.
- stat_errs, output, 16: see Optional Feature.

Behaviour:
- Reset values: state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; mem_en=0; mem_we=0; mem_addr=0; mem_wr_data=0.
- Handshake: request accepted at a posedge where req_valid && req_ready. All request fields are latched on accept; inputs are ignored otherwise.
- Little-endian lanes:
  - byte lane = addr[1:0], bits [8*lane+7 : 8*lane];
  - halfword lane = addr[1], bits [16*addr[1]+15 : 16*addr[1]].
- Errors: illegal when req_size==11, halfword with addr[0]=1, or word with addr[1:0]!=0. An illegal request never touches `sram`.
- FSM transitions:
  - IDLE: on accept go to ERR, LOAD, STORE (word store) or MERGE (sub-word store).
  - LOAD: mem_en=1, mem_addr=latched word address. At posedge, capture mem_data, extract lane, extend to 32 bits -> RESP.
  - MERGE: mem_en=1. At posedge, register mem_data with the target lane(s) replaced by req_wdata low bits; other lanes unchanged -> STORE.
  - STORE: mem_en=1, mem_we=1, mem_wr_data = merged word (or req_wdata for word stores); `sram` writes at this cycle's negedge -> RESP.
  - ERR: -> RESP with resp_err=1.
  - RESP: resp_valid=1 for exactly one cycle, req_ready=0 -> IDLE.
- Output timing: mem_* are decoded from state (combinational). mem_en=0 and mem_we=0 in IDLE, ERR and RESP; mem_addr and mem_wr_data are don't-care when mem_en=0.
- Latency, acceptance edge to resp_valid high:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 2 cycles.
- Throughput: at most one request in flight. Back-to-back requests are accepted on the cycle after RESP.
- Reset mid-operation: mem_we = (state==STORE) && !rst, so no `sram` write occurs in a cycle where rst is high. The FSM returns to IDLE on the next posedge and the pending response is dropped.
- resp_rdata/resp_err are registered and hold their value until the next RESP. They are defined only while resp_valid=1.

Optional Feature:
- Macro: MEM_ACCESS_STATS_EN.
- Defined: stat_loads, stat_stores and stat_errs are 16-bit counters.
  - Each increments by 1 in the RESP cycle of a successful load, successful store, or error respectively.
  - Counters saturate at 0xFFFF and clear on rst.
- Undefined: counter logic is not compiled; the three ports are tied to 0.

Test Plan:
- rst held 3 cycles -> req_ready=1, resp_valid=0, mem_we=0. sram word 0x10 = 0x8899AABB; load byte, addr=0x42, signed -> resp_rdata=0xFFFFFF99 two cycles after accept.
- Same word, load halfword, addr=0x42, unsigned -> resp_rdata=0x00008899.
- Same word, load word, addr=0x40 -> resp_rdata=0x8899AABB.
- Store byte 0x5A to addr=0x41 over word 0x8899AABB -> sram word 0x10 = 0x88995ABB. resp_valid 3 cycles after accept; exactly one mem_we cycle.
- Load halfword addr=0x43 -> resp_err=1, resp_rdata=0. Store with req_size=11 -> resp_err=1. In both cases mem_en stays 0 throughout.
- Assert rst during the STORE cycle of a word store of 0xDEADBEEF -> sram word unchanged, no resp_valid, state IDLE.
- With MEM_ACCESS_STATS_EN: after the above sequence, stat_loads=3, stat_stores=1, stat_errs=2. Without the macro, all three read 0.
